// File: rtl/if_id_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_queue_pkg
//  Purpose  : Shared pipeline definitions for the fetch-to-decode queue:
//             word width, bubble instruction and the {pc, inst} pair type.
//  Revision : 1.0  initial release
// ============================================================================
package if_id_queue_pkg;

    localparam int WORD_WIDTH = 32;

    // Instruction presented to decode when no real entry is available
    localparam logic [WORD_WIDTH-1:0] NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] inst;
    } if_pair_t;

endpackage
`default_nettype wire

// File: rtl/if_queue_storage.sv
`default_nettype none
// ============================================================================
//  Module   : if_queue_storage
//  Purpose  : DEPTH x WIDTH register array, synchronous write, asynchronous
//             read, cleared to zero while reset is held low.
//  Revision : 1.0  initial release
// ============================================================================
module if_queue_storage
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2 * WORD_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: whole array cleared on reset, one entry written per edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so every address value selects a real entry
    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_queue
//  Purpose  : Fetch-to-decode decoupling FIFO. Buffers {pc, inst} pairs,
//             presents the oldest to decode, back-pressures fetch when full
//             and drops every queued entry in one cycle on a branch flush.
//  Revision : 1.0  initial release
// ============================================================================
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WORD  = WORD_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD-1:0]        inPc,
    input  logic [WORD-1:0]        inInst,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic                   flush,
    output logic [WORD-1:0]        outPc,
    output logic [WORD-1:0]        outInst,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [$clog2(DEPTH):0] count
);

    localparam int                   c_PTR_W = $clog2(DEPTH);
    localparam int                   c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]   c_FULL  = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0]   c_PTR_1 = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0]   c_CNT_1 = c_CNT_W'(1);

    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_push;
    logic                w_pop;
    logic [2*WORD-1:0]   w_wdata;
    logic [2*WORD-1:0]   w_rdata;

    // Readiness depends only on occupancy: a full queue never passes through
    assign w_in_ready  = (r_count != c_FULL);
    assign w_out_valid = (r_count != '0);

    // A flush overrides both transfers in the same cycle
    assign w_push  = inValid  & w_in_ready  & ~flush;
    assign w_pop   = w_out_valid & outReady & ~flush;
    assign w_wdata = {inPc, inInst};

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_1;
            end
        end
    end

    if_queue_storage #(
        .DEPTH (DEPTH),
        .WIDTH (2 * WORD)
    ) u_storage (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Stale slots are never exposed: an empty queue shows a bubble
    assign outPc    = w_out_valid ? w_rdata[2*WORD-1:WORD] : '0;
    assign outInst  = w_out_valid ? w_rdata[WORD-1:0]      : WORD'(NOP_INST);
    assign outValid = w_out_valid;
    assign inReady  = w_in_ready;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_queue
//  Purpose  : Directed plus randomized bench for if_id_queue, checked against
//             a queue-based reference model of the FIFO behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam int DEPTH = 2;
    localparam int WORD  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [WORD-1:0] inPc;
    logic [WORD-1:0] inInst;
    logic            inValid;
    logic            inReady;
    logic            flush;
    logic [WORD-1:0] outPc;
    logic [WORD-1:0] outInst;
    logic            outValid;
    logic            outReady;
    logic [CW-1:0]   count;

    if_pair_t model_q[$];
    int       n_checks = 0;
    int       n_pass   = 0;

    if_id_queue #(
        .DEPTH (DEPTH),
        .WORD  (WORD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inPc     (inPc),
        .inInst   (inInst),
        .inValid  (inValid),
        .inReady  (inReady),
        .flush    (flush),
        .outPc    (outPc),
        .outInst  (outInst),
        .outValid (outValid),
        .outReady (outReady),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against what the model queue implies
    task automatic check_outputs(input string tag);
        int        sz;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        sz     = model_q.size();
        e_pc   = (sz != 0) ? model_q[0].pc   : 32'h0;
        e_inst = (sz != 0) ? model_q[0].inst : NOP_INST;
        check({tag, ".outValid"}, outValid, (sz != 0));
        check({tag, ".inReady"},  inReady,  (sz != DEPTH));
        check({tag, ".count"},    count,    sz);
        check({tag, ".outPc"},    outPc,    e_pc);
        check({tag, ".outInst"},  outInst,  e_inst);
    endtask

    // One clock: drive inputs, check outputs, advance model at the edge
    task automatic step(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] inst, input logic ordy, input logic fl);
        logic     do_push;
        logic     do_pop;
        if_pair_t p;
        inValid  = v;
        inPc     = pc;
        inInst   = inst;
        outReady = ordy;
        flush    = fl;
        #1;
        check_outputs(tag);
        do_push = v && (model_q.size() < DEPTH) && !fl;
        do_pop  = ordy && (model_q.size() > 0) && !fl;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                p.pc   = pc;
                p.inst = inst;
                model_q.push_back(p);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b0;
        inValid  = 1'b0;
        inPc     = '0;
        inInst   = '0;
        outReady = 1'b0;
        flush    = 1'b0;

        // Reset held low with random inputs: queue must stay empty
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            inValid  = 1'($urandom);
            inPc     = $urandom;
            inInst   = $urandom;
            outReady = 1'($urandom);
            flush    = 1'($urandom);
            #1;
            check("rst.outValid", outValid, 1'b0);
            check("rst.outInst",  outInst,  32'h0);
            check("rst.inReady",  inReady,  1'b1);
            check("rst.count",    count,    0);
        end
        @(negedge clk);
        rst = 1'b1;

        // First push becomes visible the cycle after its edge
        step("first", 1'b1, 32'h4, 32'hE3A0_0001, 1'b0, 1'b0);
        #1;
        check("first.outValid", outValid, 1'b1);
        check("first.outPc",    outPc,    32'h4);
        check("first.outInst",  outInst,  32'hE3A0_0001);
        step("clr0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Fill and stall: third pair must be refused
        step("fill0", 1'b1, 32'h4, 32'hA000_0004, 1'b0, 1'b0);
        step("fill1", 1'b1, 32'h8, 32'hA000_0008, 1'b0, 1'b0);
        #1;
        check("stall.inReady", inReady, 1'b0);
        step("fill2", 1'b1, 32'hC, 32'hA000_000C, 1'b0, 1'b0);
        #1;
        check("stall.count", count, 2);
        check("stall.head",  outPc, 32'h4);
        step("drain0", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step("drain1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step("drain2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Streaming: push and pop each cycle, occupancy never above one
        for (int k = 1; k <= 16; k++) begin
            step("stream", 1'b1, 32'(k * 4), 32'hB000_0000 + 32'(k), 1'b1, 1'b0);
            check("stream.cnt_le1", (count <= 1), 1'b1);
        end
        step("stream_end", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Wrap-around: alternate single push and single pop
        for (int k = 0; k < 5; k++) begin
            step("wrap_push", 1'b1, 32'h200 + 32'(k * 4), 32'hC000_0000 + 32'(k), 1'b0, 1'b0);
            step("wrap_pop",  1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        #1;
        check("wrap.count", count, 0);

        // Flush while full with concurrent push and pop requests
        step("fl_fill0", 1'b1, 32'h8, 32'hD000_0008, 1'b0, 1'b0);
        step("fl_fill1", 1'b1, 32'hC, 32'hD000_000C, 1'b0, 1'b0);
        step("flush",    1'b1, 32'h10, 32'hD000_0010, 1'b1, 1'b1);
        #1;
        check("flush.count",    count,    0);
        check("flush.outValid", outValid, 1'b0);
        check("flush.inReady",  inReady,  1'b1);
        step("post_flush", 1'b1, 32'h100, 32'hD000_0100, 1'b0, 1'b0);
        #1;
        check("post_flush.head", outPc, 32'h100);
        step("clr1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            step("rand", ($urandom_range(3, 0) != 0), $urandom, $urandom,
                 ($urandom_range(2, 0) != 0), ($urandom_range(15, 0) == 0));
        end

        // Asynchronous reset while full, between clock edges
        step("ar_fill0", 1'b1, 32'h300, 32'hE000_0300, 1'b0, 1'b0);
        step("ar_fill1", 1'b1, 32'h304, 32'hE000_0304, 1'b0, 1'b0);
        step("ar_fill2", 1'b1, 32'h308, 32'hE000_0308, 1'b0, 1'b0);
        inValid = 1'b1;
        inPc    = 32'h30C;
        inInst  = 32'hE000_030C;
        #2;
        rst = 1'b0;
        #1;
        check("arst.outValid", outValid, 1'b0);
        check("arst.count",    count,    0);
        check("arst.inReady",  inReady,  1'b1);
        check("arst.outPc",    outPc,    32'h0);
        check("arst.outInst",  outInst,  32'h0);
        model_q.delete();
        @(negedge clk);
        rst = 1'b1;
        step("post_arst", 1'b1, 32'h400, 32'hF000_0400, 1'b1, 1'b0);
        step("post_arst1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step("post_arst2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_id_queue.md
# if_id_queue

Fetch-to-decode decoupling queue between the instruction-fetch stage and the decode stage of the ARM pipeline. It captures {pc, instruction} pairs produced by fetch into a small circular FIFO, presents the oldest pair to decode, and back-pressures fetch through its freeze input when full. A branch-taken flush from execute discards every queued entry in one cycle, so wrong-path instructions never reach decode.

## Interface
- DEPTH, 2, number of entries; power of two, >= 2
- WORD, 32, width of pc and instruction fields
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- inPc  in  WORD  pc+4 value from fetch
- inInst  in  WORD  fetched instruction
- inValid  in  1  fetch offers a pair this cycle
- inReady  out  1  queue accepts a pair; fetch freeze = ~inReady
- flush  in  1  branch taken in execute; discard all entries
- outPc  out  WORD  pc+4 of head entry
- outInst  out  WORD  instruction of head entry
- outValid  out  1  head entry present
- outReady  in  1  decode consumes head this cycle (= ~hazard)
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- State: storage[DEPTH] of {pc, inst}, wrPtr and rdPtr ($clog2(DEPTH) bits each, wrap modulo DEPTH), count register.
- push = inValid & inReady & ~flush; pop = outValid & outReady & ~flush.
- inReady = (count != DEPTH); combinational from count only, never from outReady (no pass-through when full).
- outValid = (count != 0).
- outPc/outInst = storage[rdPtr] when outValid; both forced to 0 (NOP/bubble) when empty.
- push: storage[wrPtr] <= {inPc, inInst}; wrPtr <= wrPtr+1.
- pop: rdPtr <= rdPtr+1.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- flush: wrPtr, rdPtr, count <= 0 next edge; concurrent push and pop are both suppressed; storage contents not cleared (unreachable).
- No overflow/underflow possible by construction; push when full or pop when empty is structurally impossible and must be asserted against in verification.

## Timing
- Reset (rst = 0, asynchronous): count 0, both pointers 0, storage cleared to 0; outputs immediately outValid 0, outPc 0, outInst 0, inReady 1, count 0.
- Release of rst is sampled synchronously; first push possible on the first rising edge with rst = 1.
- Latency: pair pushed at edge N is visible on outPc/outInst with outValid = 1 after edge N (same cycle decode samples it at edge N+1); no same-cycle fall-through when empty.
- Throughput: one push and one pop per cycle sustained with DEPTH >= 2.
- Full with simultaneous pop: inReady stays 0 that cycle; push resumes the following cycle.
- Flush while full: inReady returns to 1 the cycle after the flush edge.
- Reset asserted mid-operation: all state cleared asynchronously, in-flight push discarded.
- Pointer wrap: DEPTH-1 -> 0 with no special case.

## Structure
- Shared pipeline package: WORD_WIDTH = 32, NOP_INST = 32'h0000_0000, typedef of the {pc, inst} pair (2*WORD bits).
- One sub-module: if_queue_storage, DEPTH x 2*WORD register array with synchronous write (we, waddr) and asynchronous read (raddr), reset to 0 on rst low.
- Pointer/count logic and output muxing stay in if_id_queue.

## Test plan
- Reset: hold rst = 0 with random inputs -> outValid 0, outInst 0, inReady 1, count 0; release, push {0x4, 0xE3A00001} -> next cycle outValid 1, outPc 0x4, outInst 0xE3A00001.
- Fill and stall: outReady 0, push 0x4/0x8/0xC -> count 2, inReady 0 after second push, third pair not stored; head stays 0x4.
- Streaming: outReady 1, push pc 0x4..0x40 every cycle -> outPc sequence 0x4..0x40 in order, one per cycle, count never exceeds 1, no gaps.
- Wrap-around: 5 pushes interleaved with 5 pops at DEPTH 2 -> order preserved across pointer wrap, count returns to 0.
- Flush: queue holding 0x8, 0xC, flush with inValid 1 and outReady 1 same cycle -> next cycle count 0, outValid 0, inReady 1; next push 0x100 appears as head.
- Async reset mid-stream: drop rst between edges while full -> outputs clear immediately without a clock edge.
